pc_branch_unit: RTL
===================

PC_BRANCH_UNIT -- requirements
Module: pc_branch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, program counter value loaded on reset.
REQ-002 SHALL have parameter STACK_DEPTH, default 8, number of 16-bit return-address entries (power of two, 2..8).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port flags  input  4  ALU flag register: [0] ALU-out-of-reset, [1] zero, [2] carry, [3] sign/overflow.
REQ-006 SHALL have port valid  input  1  control-flow request present.
REQ-007 SHALL have port ready  output  1  unit can accept a request this cycle.
REQ-008 SHALL have port op  input  2  00 NEXT, 01 JUMP, 10 CALL, 11 RET.
REQ-009 SHALL have port cond  input  3  000 always, 001 Z, 010 !Z, 011 C, 100 !C, 101 N, 110 !N, 111 never.
REQ-010 SHALL have port target  input  16  absolute destination for JUMP/CALL.
REQ-011 SHALL have port pc  output  16  current program counter (registered).
REQ-012 SHALL have port taken  output  1  one-cycle pulse: last completed request redirected pc.
REQ-013 SHALL have port depth  output  4  return-stack occupancy, 0..STACK_DEPTH.
REQ-014 SHALL have port stack_err  output  1  sticky flag: stack overflow or underflow occurred.

Function
REQ-015 Request SHALL be accepted only on a rising edge where valid=1 and ready=1; otherwise pc, stack and depth hold and taken=0.
REQ-016 Condition SHALL be true per cond table using flags[1], flags[2], flags[3]; if flags[0]=0, codes 001..110 SHALL evaluate false; 000 is always true and 111 always false, regardless of flags[0].
REQ-017 NEXT SHALL ignore cond and set pc<=pc+1 on the accepting edge, taken=0.
REQ-018 JUMP with true cond SHALL set pc<=target and taken=1 on the accepting edge; with false cond pc<=pc+1, taken=0.
REQ-019 CALL with true cond and depth<STACK_DEPTH SHALL push pc+1, increment depth, set pc<=target, taken=1, all on the accepting edge.
REQ-020 CALL with true cond and depth=STACK_DEPTH SHALL not push, set pc<=pc+1, taken=0, stack_err<=1.
REQ-021 RET SHALL use a two-state FSM IDLE->POP->IDLE: on acceptance enter POP (ready=0 during POP); on the POP edge, if cond true and depth>0, pc<=top entry, depth decrements, taken=1.
REQ-022 RET with true cond and depth=0 SHALL, on the POP edge, set pc<=pc+1, taken=0, stack_err<=1; RET with false cond SHALL set pc<=pc+1, taken=0, stack unchanged.
REQ-023 RET cond SHALL be sampled on the accepting edge, not re-evaluated in POP.
REQ-024 ready SHALL be 1 in IDLE and 0 in POP; non-RET requests SHALL complete in one cycle with back-to-back acceptance allowed.
REQ-025 pc+1 SHALL wrap 16'hFFFF->16'h0000 without error.
REQ-026 taken SHALL be registered and high for exactly the cycle following the pc-updating edge.
REQ-027 stack_err SHALL remain 1 until reset; the stack is LIFO, so the last pushed entry is popped first.

Reset
REQ-028 rst=0 SHALL immediately force pc=RESET_PC, depth=0, taken=0, stack_err=0, FSM=IDLE, ready=1, independent of clk.
REQ-029 Reset asserted during POP SHALL abort the return with no pc or stack update; stack contents need not be cleared.
REQ-030 After rst deasserts, the first request SHALL be accepted on the first rising edge with valid=1.

Verification
REQ-031 Reset, then 3 NEXT -> pc 0000,0001,0002,0003; taken always 0; depth 0.
REQ-032 flags=4'b0011, JUMP cond=001 target=1234 -> pc=1234, taken=1; same with flags=4'b0001 -> pc+1, taken=0; flags=4'b0010 -> pc+1 (flags[0]=0).
REQ-033 pc=0010, CALL always target=0100, then RET always -> pc=0100, depth=1; ready=0 for one cycle; pc=0011, depth=0, taken=1.
REQ-034 9 consecutive CALLs with STACK_DEPTH=8 -> depth 8, ninth gives pc+1, stack_err=1; 8 RETs return addresses in reverse push order; ninth RET -> pc+1, stack_err stays 1.
REQ-035 pc=FFFF, NEXT -> pc=0000, stack_err=0.
REQ-036 Accept RET, assert rst=0 during POP -> pc=RESET_PC, depth=0, ready=1 immediately, no taken pulse.

Source files
------------

// File: rtl/pc_branch_unit.sv
// Program-counter sequencer with conditional jump/call/return and a small
// hardware return-address stack. RET takes two cycles (IDLE -> POP -> IDLE).
module pc_branch_unit #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter int          STACK_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  flags,
  input  logic        valid,
  output logic        ready,
  input  logic [1:0]  op,
  input  logic [2:0]  cond,
  input  logic [15:0] target,
  output logic [15:0] pc,
  output logic        taken,
  output logic [3:0]  depth,
  output logic        stack_err
);

  localparam int         IDX_W     = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [3:0] DEPTH_MAX = 4'(STACK_DEPTH);

  typedef enum logic [1:0] {
    OP_NEXT = 2'b00,
    OP_JUMP = 2'b01,
    OP_CALL = 2'b10,
    OP_RET  = 2'b11
  } op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_POP  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [15:0]        pc_q, pc_d;
  logic               taken_q, taken_d;
  logic [3:0]         depth_q, depth_d;
  logic               err_q, err_d;
  logic               ret_cond_q, ret_cond_d;
  logic [15:0]        stack_q [STACK_DEPTH];

  logic               cond_true;
  logic               accept;
  logic               stack_full;
  logic               stack_empty;
  logic [15:0]        pc_inc;
  logic               push_en;
  logic [IDX_W-1:0]   push_idx;
  logic [IDX_W-1:0]   pop_idx;

  // Condition codes 001..110 are only meaningful once the ALU has left reset.
  always_comb begin
    unique case (cond)
      3'b000:  cond_true = 1'b1;
      3'b001:  cond_true = flags[0] &  flags[1];
      3'b010:  cond_true = flags[0] & ~flags[1];
      3'b011:  cond_true = flags[0] &  flags[2];
      3'b100:  cond_true = flags[0] & ~flags[2];
      3'b101:  cond_true = flags[0] &  flags[3];
      3'b110:  cond_true = flags[0] & ~flags[3];
      default: cond_true = 1'b0;
    endcase
  end

  assign accept      = valid && (state_q == S_IDLE);
  assign stack_full  = (depth_q == DEPTH_MAX);
  assign stack_empty = (depth_q == 4'd0);
  assign pc_inc      = pc_q + 16'd1;
  assign push_idx    = IDX_W'(depth_q);
  assign pop_idx     = IDX_W'(depth_q - 4'd1);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d    = state_q;
    pc_d       = pc_q;
    taken_d    = 1'b0;
    depth_d    = depth_q;
    err_d      = err_q;
    ret_cond_d = ret_cond_q;
    push_en    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          unique case (op_e'(op))
            OP_NEXT: pc_d = pc_inc;
            OP_JUMP: begin
              if (cond_true) begin
                pc_d    = target;
                taken_d = 1'b1;
              end else begin
                pc_d = pc_inc;
              end
            end
            OP_CALL: begin
              if (cond_true && !stack_full) begin
                push_en = 1'b1;
                depth_d = depth_q + 4'd1;
                pc_d    = target;
                taken_d = 1'b1;
              end else begin
                pc_d  = pc_inc;
                err_d = err_q | cond_true;
              end
            end
            OP_RET: begin
              // Condition is captured now; flags may change during POP.
              state_d    = S_POP;
              ret_cond_d = cond_true;
            end
            default: pc_d = pc_q;
          endcase
        end
      end
      S_POP: begin
        state_d = S_IDLE;
        if (ret_cond_q && !stack_empty) begin
          pc_d    = stack_q[pop_idx];
          depth_d = depth_q - 4'd1;
          taken_d = 1'b1;
        end else begin
          pc_d  = pc_inc;
          err_d = err_q | ret_cond_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      taken_q    <= 1'b0;
      depth_q    <= 4'd0;
      err_q      <= 1'b0;
      ret_cond_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      taken_q    <= taken_d;
      depth_q    <= depth_d;
      err_q      <= err_d;
      ret_cond_q <= ret_cond_d;
    end
  end

  // NOTE: the stack array is deliberately not reset; depth alone defines
  // which entries are valid, and an unreset array maps onto plain storage.
  always_ff @(posedge clk) begin
    if (push_en) begin
      stack_q[push_idx] <= pc_inc;
    end
  end

  assign ready     = (state_q == S_IDLE);
  assign pc        = pc_q;
  assign taken     = taken_q;
  assign depth     = depth_q;
  assign stack_err = err_q;

endmodule
